pipe_stage_elastic: RTL
=======================

// Module: pipe_stage_elastic
// PURPOSE
//  Parametrised elastic inter-stage pipeline register for the CPU datapath (E->M, M->W, ...).
//  Carries an opaque WIDTH-bit payload bundle with valid/ready handshaking.
//  Has an optional 2-entry skid so upstream ready is fully registered.
//  Adds synchronous flush, external stall and a saturating backpressure counter.
// PARAMETERS
//  WIDTH           64  payload bundle width in bits (all stage fields concatenated by the user)
//  SKID            1   1 = two entries (main + skid), in_ready registered; 0 = single entry, in_ready combinational
//  CLEAR_ON_FLUSH  1   1 = payload regs zeroed on flush/reset; 0 = payload held, only valid cleared
//  CNT_W           16  width of stall_cycles counter
// PORTS
//  clk           in   1        clock, rising edge
//  rst           in   1        asynchronous, active-high reset
//  flush         in   1        synchronous kill of every held entry
//  stall         in   1        freeze downstream transfer (hazard or exception hold)
//  in_valid      in   1        upstream entry valid
//  in_ready      out  1        this stage can accept an entry
//  in_data       in   WIDTH    upstream payload
//  out_valid     out  1        oldest entry valid
//  out_ready     in   1        downstream accepts
//  out_data      out  WIDTH    oldest entry payload, driven straight from the main register
//  occupancy     out  2        entries held: 0, 1 or 2
//  stall_cycles  out  CNT_W    saturating count of cycles with out_valid & ~out_fire
// BEHAVIOUR
//  - in_fire = in_valid & in_ready & ~flush.
//  - out_fire = out_valid & out_ready & ~stall & ~flush.
//  - Reset (async):
//    - state EMPTY; out_valid=0; occupancy=0; stall_cycles=0.
//    - main/skid payload = 0 regardless of CLEAR_ON_FLUSH.
//    - in_ready=1 from the first edge after release.
//  - FSM (SKID=1), registered:
//    - EMPTY: in_fire -> HALF (main<=in_data).
//    - HALF: in_fire & out_fire -> HALF (main<=in_data).
//    - HALF: in_fire & ~out_fire -> FULL (skid<=in_data, main held).
//    - HALF: ~in_fire & out_fire -> EMPTY.
//    - HALF: otherwise hold.
//    - FULL: out_fire -> HALF (main<=skid).
//    - FULL: otherwise hold.
//    - FULL: in_fire is impossible because in_ready=0.
//  - in_ready (SKID=1) = (state!=FULL), a flop output with no combinational path from out_ready or stall.
//  - SKID=0:
//    - FULL is unreachable.
//    - in_ready = ~out_valid | (out_ready & ~stall).
//    - Simultaneous in_fire and out_fire reloads main in the same cycle (zero-bubble throughput).
//  - Latency: 1 cycle from in_fire to out_valid. Throughput is 1 entry/cycle when out_ready=1 and stall=0.
//  - Order: strict FIFO. The skid entry never overtakes main.
//  - stall:
//    - Blocks out_fire only.
//    - With SKID=1 and state HALF, one further input is still absorbed into skid.
//    - out_data is stable while out_valid & ~out_fire.
//  - flush:
//    - Highest priority over stall, in_valid and out_ready.
//    - Next state EMPTY, out_valid=0, occupancy=0.
//    - An input presented in the flush cycle is dropped, not latched.
//    - The entry on out_data in the flush cycle is not transferred: out_fire is forced low.
//    - CLEAR_ON_FLUSH=1 zeroes main and skid. With 0, the payload is held but is don't-care.
//  - stall_cycles:
//    - Increments when out_valid & ~out_fire & ~flush.
//    - Saturates at 2^CNT_W-1.
//    - Cleared only by rst.
//  - Reset mid-transfer discards all entries with no partial handshake. rst dominates flush.
// STRUCTURE
//  - pipe_pkg holds the state encoding (PS_EMPTY=2'd0, PS_HALF=2'd1, PS_FULL=2'd2) and the occupancy width constant.
//  - Sub-module pipe_sat_counter #(CNT_W) (clk, rst, inc, count): saturating, async reset. Reused by other stages.
//  - Datapath is the main and skid WIDTH-bit registers plus a 2:1 mux selecting in_data or skid into main.
// TESTING
//  1 SKID=1: in_valid=1 with data 1,2,3,... every cycle, out_ready=1 -> out_data 1,2,3,... one cycle later, occupancy=1, in_ready stays 1.
//  2 SKID=1: hold entry 0xA (out_ready=0), send 0xB -> occupancy=2, in_ready=0. Raise out_ready -> 0xA then 0xB, occupancy 1 then 0.
//  3 stall=1 for 5 cycles with out_ready=1 and main=0x5 -> out_data stays 0x5, stall_cycles +5. After release, 0x5 transfers exactly once.
//  4 FULL (0xA,0xB), flush=1 with in_valid=1 data 0xC -> next cycle out_valid=0, occupancy=0, 0xC never appears, payload=0 (CLEAR_ON_FLUSH=1).
//  5 SKID=0: out_ready=0 with one entry held -> in_ready=0 the same cycle. out_ready=1 and in_valid=1 -> back-to-back transfer with no bubble.
//  6 CNT_W=4: 20 backpressure cycles -> stall_cycles=15. Async rst pulse mid-cycle -> all outputs 0 immediately.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the elastic pipeline stage family.
//   pipe_state_e - occupancy state of an elastic stage (values equal entry count)
//   OCC_W        - width of the occupancy output
//   state_occ()  - maps a state to its entry count
package pipe_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_HALF  = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_e;

    function automatic logic [OCC_W-1:0] state_occ(input pipe_state_e s);
        case (s)
            PS_HALF: return 2'd1;
            PS_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: saturating up-counter with asynchronous reset.
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset, clears count
//   inc   - count one event this cycle
//   count - current value, sticks at all-ones
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc && (count != {CNT_W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic inter-stage pipeline register with valid/ready
// handshake, optional two-entry skid, synchronous flush, external stall and a
// saturating backpressure counter.
//   clk, rst           - clock / asynchronous active-high reset
//   flush              - kills every held entry, drops the incoming one
//   stall              - blocks the downstream transfer only
//   in_valid/in_ready  - upstream handshake, in_data payload
//   out_valid/out_ready- downstream handshake, out_data from the main register
//   occupancy          - entries held (0..2)
//   stall_cycles       - saturating count of cycles holding a valid but untransferred entry
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int WIDTH          = 64,
    parameter int SKID           = 1,
    parameter int CLEAR_ON_FLUSH = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stall,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy,
    output logic [CNT_W-1:0] stall_cycles
);

    pipe_state_e      state, next_state;
    logic             rdy_q;
    logic             in_fire, out_fire;
    logic [WIDTH-1:0] main_q, skid_q, main_d;
    logic             load_main, load_skid;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= PS_EMPTY;
        else
            state <= next_state;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = PS_EMPTY;
        end else begin
            case (state)
                PS_EMPTY: if (in_fire) next_state = PS_HALF;
                PS_HALF: begin
                    // Without a skid, in_fire & ~out_fire cannot happen: in_ready
                    // already drops whenever the held entry is not leaving.
                    if (in_fire && !out_fire)
                        next_state = (SKID != 0) ? PS_FULL : PS_HALF;
                    else if (!in_fire && out_fire)
                        next_state = PS_EMPTY;
                end
                PS_FULL:  if (out_fire) next_state = PS_HALF;
                default:  next_state = PS_EMPTY;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        out_valid = (state != PS_EMPTY);
        occupancy = state_occ(state);
        // rdy_q is low in reset and rises on the first edge after release.
        // With the skid it is the whole of in_ready, so upstream sees a pure
        // flop; without it the downstream handshake passes straight through.
        in_ready  = (SKID != 0) ? rdy_q
                                : (rdy_q & (~out_valid | (out_ready & ~stall)));
        out_data  = main_q;
        in_fire   = in_valid & in_ready & ~flush;
        out_fire  = out_valid & out_ready & ~stall & ~flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdy_q <= 1'b0;
        else if (SKID != 0)
            rdy_q <= (next_state != PS_FULL);
        else
            rdy_q <= 1'b1;
    end

    // ---------------- datapath ----------------
    // main always holds the oldest entry; skid only ever holds the younger one,
    // so draining FULL moves skid into main and ordering is preserved.
    always_comb begin
        load_main = 1'b0;
        load_skid = 1'b0;
        case (state)
            PS_EMPTY: load_main = in_fire;
            PS_HALF: begin
                load_main = in_fire & out_fire;
                load_skid = in_fire & ~out_fire & (SKID != 0);
            end
            PS_FULL:  load_main = out_fire;
            default:  load_main = 1'b0;
        endcase
        main_d = (state == PS_FULL) ? skid_q : in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            if (CLEAR_ON_FLUSH != 0) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else begin
            if (load_main) main_q <= main_d;
            if (load_skid) skid_q <= in_data;
        end
    end

    // ---------------- backpressure counter ----------------
    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid & ~out_fire & ~flush),
        .count (stall_cycles)
    );

endmodule
